// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - mesh router constants and XY routing function
package noc_pkg;

  localparam int ADDR_W  = 16;
  localparam int COORD_W = 8;
  localparam int X_MSB   = 15;
  localparam int X_LSB   = 8;
  localparam int Y_MSB   = 7;
  localparam int Y_LSB   = 0;
  localparam int DIR_W   = 5;

  localparam logic [DIR_W-1:0] DIR_L  = 5'b10000;
  localparam logic [DIR_W-1:0] DIR_R  = 5'b01000;
  localparam logic [DIR_W-1:0] DIR_U  = 5'b00100;
  localparam logic [DIR_W-1:0] DIR_D  = 5'b00010;
  localparam logic [DIR_W-1:0] DIR_PE = 5'b00001;

  // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
  function automatic logic [DIR_W-1:0] xy_route(input logic [ADDR_W-1:0] dest,
                                                input logic [ADDR_W-1:0] cur);
    logic [COORD_W-1:0] dx, dy, cx, cy;
    dx = dest[X_MSB:X_LSB];
    dy = dest[Y_MSB:Y_LSB];
    cx = cur[X_MSB:X_LSB];
    cy = cur[Y_MSB:Y_LSB];
    if (dx > cx)      xy_route = DIR_R;
    else if (dx < cx) xy_route = DIR_L;
    else if (dy > cy) xy_route = DIR_U;
    else if (dy < cy) xy_route = DIR_D;
    else              xy_route = DIR_PE;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - synchronous flit FIFO with flush and look-ahead full flag
module noc_flit_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         full_next_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_eff, pop_eff;

  assign full_o      = (count_q == DEPTH_C);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign data_o      = mem_q[rd_ptr_q];
  assign full_next_o = (count_d == DEPTH_C);
  assign push_eff    = push_i & ~full_o & ~clear_i;
  assign pop_eff     = pop_i & ~empty_o & ~clear_i;

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - mesh router input port: XY route at enqueue, flit buffer, U-turn drop
module noc_input_port
  import noc_pkg::*;
#(
  parameter int          DATA_WIDTH      = 64,
  parameter int          BUFFER_DEPTH    = 4,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter logic [4:0]  DIRECTION       = 5'b00001,
  parameter int          DEST_LSB        = 0,
  parameter int          CNT_W           = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                si,
  input  logic [DATA_WIDTH-1:0]               datai,
  output logic                                ri,
  input  logic                                sig_buffer_clear,
  output logic [4:0]                          req,
  input  logic [4:0]                          gnt,
  output logic [DATA_WIDTH-1:0]               datao,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   occupancy,
  output logic                                err_drop,
  output logic [CNT_W-1:0]                    drop_cnt
);

  localparam int ENTRY_W = DATA_WIDTH + DIR_W;

  logic [DIR_W-1:0]   route;
  logic [ENTRY_W-1:0] head;
  logic               accept, uturn, push, drop, pop;
  logic               fifo_full, fifo_full_next, fifo_empty;
  logic               ri_q, ri_d;
  logic               err_drop_q, err_drop_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  assign route  = xy_route(datai[DEST_LSB +: ADDR_W], CURRENT_ADDRESS);
  assign accept = si & ri_q;
  assign uturn  = (route == DIRECTION);
  // A flush discards the offered flit silently, so it neither enqueues nor counts as a drop.
  assign push   = accept & ~uturn & ~sig_buffer_clear & ~fifo_full;
  assign drop   = accept & uturn & ~sig_buffer_clear;

  assign req    = fifo_empty ? '0 : head[DATA_WIDTH +: DIR_W];
  assign datao  = head[DATA_WIDTH-1:0];
  assign pop    = |(gnt & req);

  assign ri       = ri_q;
  assign err_drop = err_drop_q;
  assign drop_cnt = drop_cnt_q;

  noc_flit_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .data_i      ({route, datai}),
    .pop_i       (pop),
    .clear_i     (sig_buffer_clear),
    .data_o      (head),
    .full_o      (fifo_full),
    .full_next_o (fifo_full_next),
    .empty_o     (fifo_empty),
    .count_o     (occupancy)
  );

  // ready follows next-cycle occupancy so a just-filled buffer refuses the very next flit
  always_comb begin
    ri_d       = ~fifo_full_next;
    err_drop_d = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ri_q       <= 1'b0;
      err_drop_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ri_q       <= ri_d;
      err_drop_q <= err_drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
